// File: rtl/fifo_ctrl_fwft.sv
// fifo_ctrl_fwft: first-word-fall-through FIFO controller for a dual-port RAM
// with synchronous write and asynchronous read. The controller owns the
// pointers, occupancy, status flags and handshakes. The RAM's combinational
// read data is presented directly as the FIFO head, so reads take zero cycles.
module fifo_ctrl_fwft #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                afull_q, afull_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Status decoded from registered pointers only; no path from in_valid/out_ready.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  // Transfers are suppressed during flush and reset so nothing reaches the RAM.
  assign push = in_valid && !full && !flush && !rst;
  assign pop  = out_valid && out_ready && !flush && !rst;

  // RAM ports: writes never happen while full, reads only when data is present,
  // so the RAM's same-address bypass is never relied on.
  assign ram_we    = push;
  assign ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata = in_data;
  assign ram_re    = !empty;
  assign ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign out_data  = ram_rdata;

  assign level       = level_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

  // Next-state: pointer advance, occupancy, sticky errors, flush clearing.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
      if (in_valid && full)   ovf_d = 1'b1;
      if (out_ready && empty) udf_d = 1'b1;
    end

    // Derived from the next level so it changes in the same cycle as level.
    afull_d = (level_d >= AFULL_LVL);
  end

  // State register with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule
